// File: rtl/jtopl_lfo.sv
// OPL low-frequency oscillators: vibrato phase counter and tremolo triangle,
// both advanced by the cen-qualified sample strobe.
module jtopl_lfo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       zero,
   input  logic       am_dep,
   output logic [4:0] lfo_mod,
   output logic [4:0] am
);

   logic       tick;
   logic [7:0] vib_pre;
   logic [5:0] trem_pre;
   logic [7:0] am_cnt;

   assign tick = cen & zero;

   // Fold the 0..209 step count into a 0..104 triangle, peak held for two steps.
   function automatic logic [7:0] tri_wave(input logic [7:0] cnt);
      return (cnt < 8'd105) ? cnt : (8'd209 - cnt);
   endfunction

   function automatic logic [4:0] depth_scale(input logic [7:0] t, input logic dep);
      return dep ? 5'(t >> 2) : 5'(t >> 4);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vib_pre  <= 8'd0;
         lfo_mod  <= 5'd0;
         trem_pre <= 6'd0;
         am_cnt   <= 8'd0;
      end else if (tick) begin
         vib_pre  <= vib_pre + 8'd1;
         trem_pre <= trem_pre + 6'd1;
         if (vib_pre == 8'hff)
            lfo_mod <= lfo_mod + 5'd1;
         if (trem_pre == 6'd63)
            am_cnt <= (am_cnt == 8'd209) ? 8'd0 : am_cnt + 8'd1;
      end
   end

   // Depth output refreshes on every enabled cycle, so an am_dep change shows up
   // one cen cycle later even without a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         am <= 5'd0;
      else if (cen)
         am <= depth_scale(tri_wave(am_cnt), am_dep);
   end

endmodule

// File: doc/jtopl_lfo.md
JTOPL_LFO -- requirements
Module: jtopl_lfo

Interface
REQ-001 The block SHALL have no parameters; all step counts and periods below are fixed.
REQ-002 Port: clk  input  1  system clock; single clock domain.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: cen  input  1  clock enable; no state changes when low.
REQ-005 Port: zero  input  1  sample strobe, one cen-qualified cycle per output sample.
REQ-006 Port: am_dep  input  1  global tremolo depth: 1 = 4.8 dB, 0 = 1 dB.
REQ-007 Port: lfo_mod  output  5  vibrato LFO phase, feeds the phase modulator (bit 4 = sign, bit 3 = half reversal, bits 2:0 = index).
REQ-008 Port: am  output  5  tremolo attenuation value, unsigned, depth already applied.

Function
REQ-009 The block SHALL define an advance tick as a clk rising edge with cen=1 and zero=1; zero with cen=0 is ignored.
REQ-010 Vibrato prescaler: 8-bit counter, +1 per advance tick, wraps 255->0.
REQ-011 lfo_mod SHALL increment by 1 on the advance tick where the vibrato prescaler wraps 255->0, and SHALL wrap 31->0.
REQ-012 Vibrato period SHALL be 32 x 256 = 8192 ticks (~6.07 Hz at 49716 Hz).
REQ-013 lfo_mod SHALL be the counter register itself (no extra latency).
REQ-014 Tremolo prescaler: 6-bit counter, +1 per advance tick, wraps 63->0.
REQ-015 Tremolo step counter am_cnt, 8-bit, range 0..209, SHALL increment on the tick where the tremolo prescaler wraps; 209->0.
REQ-016 Tremolo period SHALL be 210 x 64 = 13440 ticks (~3.7 Hz).
REQ-017 Triangle tri = am_cnt when am_cnt<105, else 209-am_cnt; range 0..104, peak value 104 held for am_cnt 104 and 105.
REQ-018 am SHALL be registered as tri>>2 (0..26) when am_dep=1, tri>>4 (0..6) when am_dep=0.
REQ-019 The am register SHALL update on every clk edge with cen=1, from the current am_cnt and am_dep, giving one cen-cycle latency after an am_cnt change or an am_dep change.
REQ-020 Widths: tri SHALL be computed unsigned with no truncation before the depth shift; am SHALL never exceed 26.
REQ-021 Both prescalers SHALL run unconditionally; vibrato and tremolo enables are applied downstream, not here.
REQ-022 Counters are free-running and have no state machine beyond them; key-on and register writes SHALL NOT reset them.
REQ-023 A simultaneous wrap of both prescalers on the same tick SHALL advance both lfo_mod and am_cnt on that tick.

Reset
REQ-024 rst_n low SHALL clear immediately, without clk: both prescalers, lfo_mod=0, am_cnt=0, am=0.
REQ-025 Reset asserted mid-period SHALL discard the partial prescaler count; after release, counting SHALL restart from 0 on the first advance tick.
REQ-026 Reset deassertion SHALL take effect on the next clk edge; no tick SHALL be lost or doubled at release.

Verification
REQ-027 Reset: drive rst_n=0 between clk edges during activity -> lfo_mod=0 and am=0 immediately; after release with zero held low, outputs stay 0.
REQ-028 Vibrato: apply 255 ticks -> lfo_mod=0; 256th tick -> lfo_mod=1; 8192 ticks total -> lfo_mod=0 (wrapped from 31); at tick 7936, lfo_mod=31.
REQ-029 Tremolo, am_dep=1: at am_cnt=104 (6656 ticks) am=26; at am_cnt=105 am=26; at am_cnt=209 am=0; after 13440 ticks am_cnt=0 and am=0.
REQ-030 Depth switch: at am_cnt=104 set am_dep=0 -> am=6 one cen cycle later; set am_dep=1 -> am=26 one cen cycle later.
REQ-031 Clock enable: hold zero=1 with cen=0 for 1000 clk cycles -> no change in lfo_mod, am, or either prescaler; then alternating cen -> advance exactly once per cen-qualified zero.
REQ-032 Joint wrap: run to tick 256 (both prescalers wrap, since 256 = 4 x 64) -> lfo_mod=1 and am_cnt=4 on the same edge.
